simd_mac_ctrl: RTL and testbench
================================

SIMD_MAC_CTRL -- requirements
Module: simd_mac_ctrl

Interface
REQ-001 Parameter: col, 8, number of mac tiles per array row.
REQ-002 Parameter: row, 8, number of tile rows.
REQ-003 Parameter: len_bw, 8, width of the activation-length field.
REQ-004 Parameter: addr_bw, 11, width of the SRAM address outputs.
REQ-005 Ports SHALL be, one per line:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- mode  input  1  1 = 4-bit weight mode, 0 = 2-bit mode; latched on accepted start.
- act_len  input  len_bw  number of activation vectors; latched on accepted start.
- stall  input  1  downstream output FIFO full; pauses EXEC.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on job completion.
- arr_reset  output  1  tile-array reset, which clears the tiles' weight-loaded flags.
- w_rd_en  output  1  weight SRAM read enable.
- w_addr  output  addr_bw  weight SRAM address.
- a_rd_en  output  1  activation SRAM read enable.
- a_addr  output  addr_bw  activation SRAM address.
- inst_w  output  3  array instruction: [2] mode, [1] execute, [0] weight load.

Function
REQ-006 FSM states SHALL be IDLE, CLR, LOAD, FLUSH, EXEC, DRAIN, DONE.
REQ-007 IDLE -> CLR SHALL occur on start=1; start SHALL be ignored in all other states.
REQ-008 CLR SHALL last exactly 1 cycle with arr_reset=1, then go to LOAD.
REQ-009 LOAD SHALL issue W consecutive weight reads, with w_addr 0..W-1 and w_rd_en=1.
- W = col in 4-bit mode; W = 2*col in 2-bit mode.
REQ-010 SRAM read latency is 1 cycle, so inst_w SHALL lag the matching rd_en by exactly 1 cycle to align with read data.
REQ-011 inst_w[0] SHALL be 1 for the W data cycles and for the following FLUSH cycles.
REQ-012 FLUSH SHALL last col cycles, with w_rd_en=0; weight data during FLUSH is don't-care.
REQ-013 After FLUSH, the FSM SHALL go to EXEC, or to DRAIN if the latched act_len==0.
REQ-014 EXEC SHALL issue act_len activation reads: a_addr 0..act_len-1, a_rd_en=1, and 1-cycle-lagged inst_w = {mode,1,0}.
REQ-015 In EXEC with stall=1: a_rd_en=0, a_addr holds, and the matching lagged inst_w[1]=0.
- No address SHALL be skipped or duplicated across stalls.
REQ-016 DRAIN SHALL last row+col-1 cycles with inst_w = {mode,0,0}; stall SHALL NOT extend DRAIN.
REQ-017 DONE SHALL last 1 cycle with done=1, then return to IDLE; busy SHALL be 0 in the cycle after done.
REQ-018 inst_w[2] SHALL equal the latched mode whenever busy=1, and SHALL be 0 in IDLE.
REQ-019 mode and act_len changes while busy=1 SHALL have no effect on the current job.
REQ-020 Counters SHALL be sized so that W, row+col-1 and 2^len_bw-1 never wrap.
- act_len=2^len_bw-1 SHALL complete with exactly that many reads.
REQ-021 Address outputs SHALL be zero-extended counter values; they SHALL be 0 when the matching rd_en=0 outside EXEC stalls.

Reset
REQ-022 reset=1 SHALL force IDLE on the next clock edge, including mid-job.
REQ-023 Reset values SHALL be: busy=0, done=0, arr_reset=0, w_rd_en=0, a_rd_en=0, w_addr=0, a_addr=0, inst_w=3'b000.
- Any pending lagged instruction SHALL be cleared.
REQ-024 After reset the block SHALL accept start on the first cycle that reset=0.

Verification
REQ-025 2-bit job with col=8, row=8, act_len=4, no stall -> the bench SHALL observe, in order:
- 1 arr_reset cycle;
- 16 w_rd_en cycles with w_addr 0..15;
- 8 FLUSH cycles;
- 4 a_rd_en cycles with a_addr 0..3;
- 15 DRAIN cycles;
- done pulse at cycle 45 after start.
REQ-026 4-bit job, act_len=2 -> 8 weight reads (w_addr 0..7); inst_w[2]=1 throughout the job; done at cycle 35.
REQ-027 act_len=3 with stall=1 on the 2nd EXEC cycle only -> a_addr sequence 0,1,1(a_rd_en=0),2; inst_w[1] pattern 1,0,1,1 lagged by 1 cycle; done is delayed by exactly 1 cycle.
REQ-028 act_len=0 -> EXEC is skipped; FLUSH goes directly to 15 DRAIN cycles, then done.
REQ-029 reset asserted during the 5th LOAD cycle -> all outputs return to reset values on the next cycle; a following start runs a full job with w_addr starting at 0.
REQ-030 start held high continuously across 2 jobs -> the 2nd job begins in the cycle after DONE returns the FSM to IDLE; start is ignored while busy.

Source files
------------

// File: rtl/simd_mac_ctrl.sv
// Sequencer for a SIMD MAC tile array: clears the tiles, streams weights in,
// flushes the weight pipeline, streams activations (honouring downstream
// back-pressure), drains the array and signals completion.
module simd_mac_ctrl #(
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [len_bw-1:0]  act_len,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               arr_reset,
    output logic               w_rd_en,
    output logic [addr_bw-1:0] w_addr,
    output logic               a_rd_en,
    output logic [addr_bw-1:0] a_addr,
    output logic [2:0]         inst_w
);

    // One shared counter walks every multi-cycle phase, so it must hold the
    // largest of: 2*col weight reads, row+col-1 drain cycles, 2^len_bw-1 reads.
    localparam int WCNT_W = $clog2(2 * col + 1);
    localparam int DCNT_W = $clog2(row + col + 1);
    localparam int MAX_WD = (WCNT_W > DCNT_W) ? WCNT_W : DCNT_W;
    localparam int CNT_W  = (MAX_WD > len_bw) ? MAX_WD : len_bw;

    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(row + col - 2);
    localparam logic [CNT_W-1:0] W4_LAST    = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] W2_LAST    = CNT_W'(2 * col - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        FLUSH,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic [len_bw-1:0] actLen_q, actLen_d;
    logic              instLoad_q, instLoad_d;
    logic              instExec_q, instExec_d;

    logic [CNT_W-1:0]  wLast;
    logic [CNT_W-1:0]  execLast;

    // 4-bit weights need one word per tile column, 2-bit weights need two.
    assign wLast    = mode_q ? W4_LAST : W2_LAST;
    assign execLast = CNT_W'(actLen_q) - CNT_W'(1);

    // The instruction bits follow their SRAM reads by one cycle so that they
    // arrive at the array together with the read data.
    assign instLoad_d = (state_q == LOAD) || (state_q == FLUSH);
    assign instExec_d = a_rd_en;
    assign inst_w     = {busy & mode_q, instExec_q, instLoad_q};

    // State, counter, latched job parameters and lagged instruction bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= 1'b0;
            actLen_q   <= '0;
            instLoad_q <= 1'b0;
            instExec_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            actLen_q   <= actLen_d;
            instLoad_q <= instLoad_d;
            instExec_q <= instExec_d;
        end
    end

    // Next-state sequencing and per-state SRAM/array controls.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        actLen_d  = actLen_q;
        busy      = (state_q != IDLE);
        done      = 1'b0;
        arr_reset = 1'b0;
        w_rd_en   = 1'b0;
        w_addr    = '0;
        a_rd_en   = 1'b0;
        a_addr    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CLR;
                    mode_d   = mode;
                    actLen_d = act_len;
                    cnt_d    = '0;
                end
            end
            CLR: begin
                arr_reset = 1'b1;
                cnt_d     = '0;
                state_d   = LOAD;
            end
            LOAD: begin
                w_rd_en = 1'b1;
                w_addr  = addr_bw'(cnt_q);
                if (cnt_q == wLast) begin
                    cnt_d   = '0;
                    state_d = FLUSH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = (actLen_q == '0) ? DRAIN : EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EXEC: begin
                a_addr = addr_bw'(cnt_q);
                if (!stall) begin
                    a_rd_en = 1'b1;
                    if (cnt_q == execLast) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_simd_mac_ctrl.sv
// Scoreboard bench for simd_mac_ctrl: each job's expected cycle-by-cycle
// outputs are queued when the job is started and popped every cycle.
module tb_simd_mac_ctrl;

    localparam int COL    = 8;
    localparam int ROW    = 8;
    localparam int LEN_BW = 8;
    localparam int ADDR_BW = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mode;
    logic [LEN_BW-1:0] act_len;
    logic              stall;
    logic              busy;
    logic              done;
    logic              arr_reset;
    logic              w_rd_en;
    logic [ADDR_BW-1:0] w_addr;
    logic              a_rd_en;
    logic [ADDR_BW-1:0] a_addr;
    logic [2:0]        inst_w;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        arr;
        logic        wr;
        logic [10:0] wa;
        logic        ar;
        logic [10:0] aa;
        logic [2:0]  iw;
    } obs_t;

    obs_t sb[$];
    int   errors = 0;
    int   checks = 0;

    simd_mac_ctrl #(
        .col(COL), .row(ROW), .len_bw(LEN_BW), .addr_bw(ADDR_BW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .act_len(act_len), .stall(stall), .busy(busy), .done(done),
        .arr_reset(arr_reset), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .inst_w(inst_w)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    function automatic obs_t mk(input bit b, input bit d, input bit ar, input bit wr,
                                input int wa, input bit rd, input int aa,
                                input logic [2:0] iw);
        obs_t o;
        o.busy = b;
        o.done = d;
        o.arr  = ar;
        o.wr   = wr;
        o.wa   = 11'(wa);
        o.ar   = rd;
        o.aa   = 11'(aa);
        o.iw   = iw;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o = {busy, done, arr_reset, w_rd_en, w_addr, a_rd_en, a_addr, inst_w};
        return o;
    endfunction

    // Expected outputs for cycles 1..done+1 of a job; stallAt is the EXEC
    // cycle index held off by stall (-1 for none).
    task automatic push_job(input bit m, input int al, input int stallAt);
        int wCnt;
        int addr;
        int j;
        bit pw;
        bit px;
        bit st;
        wCnt = m ? COL : 2 * COL;
        pw = 1'b0;
        px = 1'b0;
        sb.push_back(mk(1, 0, 1, 0, 0, 0, 0, {m, px, pw}));
        for (int i = 0; i < wCnt; i++) begin
            sb.push_back(mk(1, 0, 0, 1, i, 0, 0, {m, px, pw}));
            pw = 1'b1;
            px = 1'b0;
        end
        for (int i = 0; i < COL; i++) begin
            sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, {m, px, pw}));
            pw = 1'b1;
            px = 1'b0;
        end
        addr = 0;
        j = 0;
        while (addr < al) begin
            st = (j == stallAt);
            sb.push_back(mk(1, 0, 0, 0, 0, !st, addr, {m, px, pw}));
            pw = 1'b0;
            px = !st;
            if (!st) addr++;
            j++;
        end
        for (int i = 0; i < ROW + COL - 1; i++) begin
            sb.push_back(mk(1, 0, 0, 0, 0, 0, 0, {m, px, pw}));
            pw = 1'b0;
            px = 1'b0;
        end
        sb.push_back(mk(1, 1, 0, 0, 0, 0, 0, {m, px, pw}));
        sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'b000));
    endtask

    // Entered in cycle 0 with start already driven; consumes the scoreboard.
    task automatic run_sb(input string name, input bit hold, input int stallCycle,
                          input int stallFrom, input bit nextMode, input int nextLen,
                          output int firstDone, output int doneCount);
        int   cyc;
        obs_t act;
        obs_t expv;
        firstDone = -1;
        doneCount = 0;
        @(posedge clk);
        #1;
        cyc = 1;
        while (sb.size() > 0 && cyc < 3000) begin
            start = hold && (sb.size() > 1);
            if (hold && sb.size() > 1 && sb[0].busy == 1'b0) begin
                mode    = nextMode;
                act_len = LEN_BW'(nextLen);
            end else begin
                mode    = 1'($urandom);
                act_len = LEN_BW'($urandom);
            end
            stall = (cyc == stallCycle) || (stallFrom > 0 && cyc >= stallFrom);
            @(negedge clk);
            expv = sb.pop_front();
            act  = sample();
            checks++;
            if (act !== expv) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cyc, act, expv);
            end
            if (act.done === 1'b1) begin
                doneCount++;
                if (firstDone < 0) firstDone = cyc;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got %0d pending expected 0", name, sb.size());
            sb.delete();
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic check_int(input string name, input int got, input int expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic test_reset();
        obs_t act;
        reset   = 1'b1;
        start   = 1'b1;
        mode    = 1'b1;
        act_len = 8'd5;
        stall   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            act = sample();
            checks++;
            if (act !== '0) begin
                errors++;
                $display("[TB] FAIL reset_values: got %h expected 0", act);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Starts on the very first cycle with reset low; stall in DRAIN is ignored.
    task automatic test_2bit_job();
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b0;
        act_len = 8'd4;
        push_job(1'b0, 4, -1);
        run_sb("job_2bit", 1'b0, -1, 30, 1'b0, 0, fd, dc);
        check_int("done_cycle_2bit", fd, 45);
        check_int("done_count_2bit", dc, 1);
    endtask

    task automatic test_4bit_job();
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b1;
        act_len = 8'd2;
        push_job(1'b1, 2, -1);
        run_sb("job_4bit", 1'b0, -1, -1, 1'b0, 0, fd, dc);
        check_int("done_cycle_4bit", fd, 35);
    endtask

    task automatic test_stall();
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b0;
        act_len = 8'd3;
        push_job(1'b0, 3, 1);
        run_sb("stall", 1'b0, 27, -1, 1'b0, 0, fd, dc);
        check_int("done_cycle_stall", fd, 45);
    endtask

    task automatic test_zero_len();
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b1;
        act_len = 8'd0;
        push_job(1'b1, 0, -1);
        run_sb("zero_len", 1'b0, -1, 1, 1'b0, 0, fd, dc);
        check_int("done_cycle_zero_len", fd, 33);
    endtask

    task automatic test_reset_mid_load();
        obs_t act;
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b0;
        act_len = 8'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_int("load5_w_addr", int'(w_addr), 4);
        check_int("load5_w_rd_en", int'(w_rd_en), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        act = sample();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("[TB] FAIL mid_load_reset: got %h expected 0", act);
        end
        @(posedge clk);
        #1;
        start   = 1'b1;
        mode    = 1'b1;
        act_len = 8'd1;
        push_job(1'b1, 1, -1);
        run_sb("after_reset", 1'b0, -1, -1, 1'b0, 0, fd, dc);
        check_int("done_cycle_after_reset", fd, 34);
    endtask

    task automatic test_back_to_back();
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b0;
        act_len = 8'd2;
        push_job(1'b0, 2, -1);
        push_job(1'b1, 1, -1);
        run_sb("back_to_back", 1'b1, -1, -1, 1'b1, 1, fd, dc);
        check_int("done_cycle_b2b", fd, 43);
        check_int("done_count_b2b", dc, 2);
    endtask

    task automatic test_max_len();
        int fd;
        int dc;
        start   = 1'b1;
        mode    = 1'b1;
        act_len = 8'd255;
        push_job(1'b1, 255, -1);
        run_sb("max_len", 1'b0, -1, -1, 1'b0, 0, fd, dc);
        check_int("done_cycle_max_len", fd, 288);
    endtask

    // Runs every scenario in order and prints the summary.
    initial begin
        test_reset();
        test_2bit_job();
        test_4bit_job();
        test_stall();
        test_zero_len();
        test_reset_mid_load();
        test_back_to_back();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
